// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register: valid/ready handshake, registered in_ready_o, 2-entry skid buffer.
// Optional statistics counters are compiled in when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_skid #(
    parameter int                DATA_W      = 32 + 64,
    parameter logic [DATA_W-1:0] FLUSH_VALUE = '0,
    parameter int                CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q;
    logic              in_xfer;
    logic              out_xfer;

    assign in_xfer     = in_valid_i & in_ready_q;
    assign out_xfer    = out_valid_o & out_ready_i;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = main_q;

    // MAIN drives the outputs; SKID only catches the one beat accepted while MAIN was stalled.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = FLUSH_VALUE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_data_i;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (out_xfer && in_xfer) begin
                        main_d = in_data_i;
                    end else if (out_xfer) begin
                        main_d  = FLUSH_VALUE;
                        state_d = ST_EMPTY;
                    end else if (in_xfer) begin
                        skid_d  = in_data_i;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    // in_ready_o is low here, so only the drain side can move.
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    main_d  = FLUSH_VALUE;
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= FLUSH_VALUE;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    // NOTE: skid payload has no reset; it is only ever read when the state says it holds a valid beat.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    // Saturating counters; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid_o && !out_ready_i && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (!out_valid_o && (bubble_q != '1)) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o  = stall_q;
    assign bubble_cnt_o = bubble_q;
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios with literal expectations plus a randomized run
// compared each cycle against a queue-based model of a 2-deep FIFO stage.
module tb_pipe_stage_skid;

    localparam int                DATA_W      = 96;
    localparam logic [DATA_W-1:0] FLUSH_VALUE = 96'h13;
    localparam int                CNT_W       = 4;
    localparam int                CNT_MAX     = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W      (DATA_W),
        .FLUSH_VALUE (FLUSH_VALUE),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .stall_cnt_o  (stall_cnt),
        .bubble_cnt_o (bubble_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: the stage is a FIFO of depth 2; accepts when fewer than 2 are held at the edge.
    logic [DATA_W-1:0] m_q[$];
    int                m_stall;
    int                m_bubble;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_stall  <= 0;
            m_bubble <= 0;
        end else begin
            if (m_q.size() > 0 && !out_ready && m_stall < CNT_MAX) m_stall <= m_stall + 1;
            if (m_q.size() == 0 && m_bubble < CNT_MAX) m_bubble <= m_bubble + 1;
            if (flush) begin
                m_q.delete();
            end else begin
                logic take;
                take = in_valid && (m_q.size() < 2);
                if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
                if (take) m_q.push_back(in_data);
            end
        end
    end

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_valid", DATA_W'(out_valid), DATA_W'(m_q.size() > 0));
            check("model_ready", DATA_W'(in_ready), DATA_W'(m_q.size() < 2));
            check("model_data", out_data, (m_q.size() > 0) ? m_q[0] : FLUSH_VALUE);
`ifdef PIPE_STAGE_STATS_EN
            check("model_stall_cnt", DATA_W'(stall_cnt), DATA_W'(m_stall));
            check("model_bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(m_bubble));
`else
            check("model_stall_cnt", DATA_W'(stall_cnt), '0);
            check("model_bubble_cnt", DATA_W'(bubble_cnt), '0);
`endif
        end
    end

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(negedge clk);
    endtask

    logic              gen_v;
    logic [DATA_W-1:0] gen_d;
    logic              gen_acc;

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        check("reset_valid", DATA_W'(out_valid), '0);
        check("reset_data", out_data, 96'h13);
        check("reset_ready", DATA_W'(in_ready), 96'h1);
        check("reset_stall_cnt", DATA_W'(stall_cnt), '0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Streaming: one beat per cycle, one cycle of latency
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, DATA_W'(k), 1'b1, 1'b0);
            check("stream_valid", DATA_W'(out_valid), 96'h1);
            check("stream_data", out_data, DATA_W'(k));
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        check("stream_drain_valid", DATA_W'(out_valid), '0);
        check("stream_drain_data", out_data, 96'h13);

        // Back-pressure: skid fills on B, C is held upstream
        drive(1'b1, 96'hA, 1'b0, 1'b0);
        check("bp_ready_after_a", DATA_W'(in_ready), 96'h1);
        check("bp_data_a", out_data, 96'hA);
        drive(1'b1, 96'hB, 1'b0, 1'b0);
        check("bp_ready_after_b", DATA_W'(in_ready), '0);
        check("bp_hold_a1", out_data, 96'hA);
        drive(1'b1, 96'hC, 1'b0, 1'b0);
        check("bp_hold_a2", out_data, 96'hA);
        drive(1'b1, 96'hC, 1'b0, 1'b0);
        check("bp_hold_a3", out_data, 96'hA);
        check("bp_ready_stalled", DATA_W'(in_ready), '0);
        drive(1'b1, 96'hC, 1'b1, 1'b0);
        check("bp_out_b", out_data, 96'hB);
        check("bp_ready_release", DATA_W'(in_ready), 96'h1);
        drive(1'b1, 96'hC, 1'b1, 1'b0);
        check("bp_out_c", out_data, 96'hC);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("bp_empty", DATA_W'(out_valid), '0);

        // Flush while full with a beat offered upstream
        drive(1'b1, 96'h21, 1'b0, 1'b0);
        drive(1'b1, 96'h22, 1'b0, 1'b0);
        check("fl_full_ready", DATA_W'(in_ready), '0);
        drive(1'b1, 96'hD, 1'b0, 1'b1);
        check("fl_valid", DATA_W'(out_valid), '0);
        check("fl_data", out_data, 96'h13);
        check("fl_ready", DATA_W'(in_ready), 96'h1);
        repeat (3) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            check("fl_no_d", DATA_W'(out_valid), '0);
        end
        // Flush in ONE discards a concurrently accepted beat
        drive(1'b1, 96'h31, 1'b0, 1'b0);
        drive(1'b1, 96'hE, 1'b1, 1'b1);
        check("fl_one_valid", DATA_W'(out_valid), '0);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("fl_one_no_e", DATA_W'(out_valid), '0);

        // Reset while full
        drive(1'b1, 96'h51, 1'b0, 1'b0);
        drive(1'b1, 96'h52, 1'b0, 1'b0);
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        check("rst_full_valid", DATA_W'(out_valid), '0);
        check("rst_full_data", out_data, 96'h13);
        check("rst_full_ready", DATA_W'(in_ready), 96'h1);
        check("rst_full_stall_cnt", DATA_W'(stall_cnt), '0);
        rst_n = 1'b1;

        // Stall for 20 cycles: counter saturates
        drive(1'b1, 96'h41, 1'b0, 1'b0);
        repeat (20) drive(1'b0, '0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_STATS_EN
        check("sat_stall_cnt", DATA_W'(stall_cnt), 96'hF);
        check("sat_bubble_cnt", DATA_W'(bubble_cnt), 96'h1);
`else
        check("sat_stall_cnt", DATA_W'(stall_cnt), '0);
        check("sat_bubble_cnt", DATA_W'(bubble_cnt), '0);
`endif
        check("sat_hold_data", out_data, 96'h41);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic; upstream holds each beat until accepted
        gen_v   = 1'b0;
        gen_d   = '0;
        gen_acc = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!gen_v || gen_acc) begin
                gen_v = ($urandom_range(0, 3) != 0);
                gen_d = {$urandom(), $urandom(), $urandom()};
            end
            gen_acc = gen_v && (m_q.size() < 2);
            drive(gen_v, gen_d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0));
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
